// File: rtl/mux_n_scan.sv
// Registered N:1 channel multiplexer with host-driven DIRECT mode and a
// round-robin SCAN mode that dwells DWELL cycles on each masked-in channel.
module mux_n_scan #(
  parameter int N     = 16,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   inp,
  input  logic             mode,
  input  logic [SEL_W-1:0] select,
  input  logic             enable,
  input  logic [N-1:0]     chan_mask,
  output logic [W-1:0]     out,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  output logic             wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {S_DIRECT, S_SCAN} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_nxt;
  logic [W-1:0]     out_nxt;
  logic [SEL_W-1:0] out_ch_nxt;
  logic             out_valid_nxt;
  logic             wrap_nxt;

  logic [W-1:0]     chans [N];
  logic [SEL_W-1:0] lowest;
  logic [SEL_W-1:0] next_ptr;
  logic             select_ok;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chans[k] = inp[k*W +: W];
  end

  assign select_ok = (int'(select) < N);

  always_comb begin
    lowest = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (chan_mask[i]) lowest = SEL_W'(i);
    end
  end

  // First masked-in channel strictly after ptr, searching circularly;
  // lands back on ptr itself when it is the only channel in the mask.
  always_comb begin
    logic found;
    int   idx;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && chan_mask[idx]) begin
        next_ptr = SEL_W'(idx);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    dwell_cnt_nxt = dwell_cnt;
    out_nxt       = out;
    out_ch_nxt    = out_ch;
    out_valid_nxt = 1'b0;
    wrap_nxt      = 1'b0;

    if (enable) begin
      if (!mode) begin
        state_nxt  = S_DIRECT;
        out_ch_nxt = select;
        if (select_ok) begin
          out_nxt       = chans[select];
          out_valid_nxt = 1'b1;
        end else begin
          out_nxt = '0;
        end
      end else if (state == S_DIRECT) begin
        // Entry cycle only lines the pointer up; data starts next cycle.
        state_nxt     = S_SCAN;
        ptr_nxt       = lowest;
        dwell_cnt_nxt = '0;
      end else begin
        out_nxt       = chans[ptr];
        out_ch_nxt    = ptr;
        out_valid_nxt = chan_mask[ptr];
        if (chan_mask != '0) begin
          if (!chan_mask[ptr] || dwell_cnt == CNT_W'(DWELL - 1)) begin
            ptr_nxt       = next_ptr;
            dwell_cnt_nxt = '0;
            wrap_nxt      = (next_ptr <= ptr);
          end else begin
            dwell_cnt_nxt = dwell_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_DIRECT;
      ptr       <= '0;
      dwell_cnt <= '0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      out       <= out_nxt;
      out_ch    <= out_ch_nxt;
      out_valid <= out_valid_nxt;
      wrap      <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mux_n_scan.sv
// Directed, table-driven bench for mux_n_scan (N=16, W=8, DWELL=4) with
// hand-written sequences for the data-change and asynchronous-reset cases.
module tb_mux_n_scan;

  localparam int N = 16;
  localparam int W = 8;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   inp;
  logic             mode;
  logic [SEL_W-1:0] select;
  logic             enable;
  logic [N-1:0]     chan_mask;
  logic [W-1:0]     out;
  logic [SEL_W-1:0] out_ch;
  logic             out_valid;
  logic             wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic [N-1:0]     mask;
    logic [W-1:0]     e_out;
    logic [SEL_W-1:0] e_ch;
    logic             e_valid;
    logic             e_wrap;
  } vec_t;

  vec_t vecs[$];

  mux_n_scan #(.N(N), .W(W), .DWELL(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp),
    .mode      (mode),
    .select    (select),
    .enable    (enable),
    .chan_mask (chan_mask),
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic void push(input logic m, input int sel, input logic en,
                               input logic [N-1:0] mask, input logic [W-1:0] eo,
                               input int ech, input logic ev, input logic ew);
    vec_t v;
    v.mode = m; v.sel = SEL_W'(sel); v.en = en; v.mask = mask;
    v.e_out = eo; v.e_ch = SEL_W'(ech); v.e_valid = ev; v.e_wrap = ew;
    vecs.push_back(v);
  endfunction

  function automatic void pushN(input int count, input logic m, input logic en,
                                input logic [N-1:0] mask, input logic [W-1:0] eo,
                                input int ech, input logic ev, input logic ew);
    for (int i = 0; i < count; i++) push(m, 0, en, mask, eo, ech, ev, ew);
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] eo,
                             input logic [SEL_W-1:0] ech, input logic ev, input logic ew);
    checks++;
    if (out !== eo || out_ch !== ech || out_valid !== ev || wrap !== ew) begin
      errors++;
      $display("[TB] FAIL %s: got out=%h ch=%0d valid=%b wrap=%b, expected out=%h ch=%0d valid=%b wrap=%b",
               name, out, out_ch, out_valid, wrap, eo, ech, ev, ew);
    end
  endtask

  task automatic applyStimulus(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      mode = vecs[i].mode;
      select = vecs[i].sel;
      enable = vecs[i].en;
      chan_mask = vecs[i].mask;
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_ch,
                  vecs[i].e_valid, vecs[i].e_wrap);
    end
  endtask

  task automatic setDefaultInp();
    for (int k = 0; k < N; k++) inp[k*W +: W] = 8'(8'hA0 + k);
  endtask

  int a_end, b_end, c_end;

  initial begin
    // Phase A: DIRECT select stepping
    push(0, 0, 1, 16'h0, 8'hA0, 0, 1, 0);
    push(0, 1, 1, 16'h0, 8'hA1, 1, 1, 0);
    push(0, 15, 1, 16'h0, 8'hAF, 15, 1, 0);
    push(0, 9, 1, 16'h0, 8'hA9, 9, 1, 0);
    a_end = vecs.size();
    // Phase B: SCAN rotation, empty mask, single channel, enable freeze
    push(0, 9, 1, 16'h0, 8'hA9, 9, 1, 0);
    push(1, 0, 1, 16'h8101, 8'hA9, 9, 0, 0);
    pushN(4, 1, 1, 16'h8101, 8'hA0, 0, 1, 0);
    pushN(4, 1, 1, 16'h8101, 8'hA8, 8, 1, 0);
    pushN(3, 1, 1, 16'h8101, 8'hAF, 15, 1, 0);
    pushN(1, 1, 1, 16'h8101, 8'hAF, 15, 1, 1);
    pushN(4, 1, 1, 16'h8101, 8'hA0, 0, 1, 0);
    pushN(2, 1, 1, 16'h8101, 8'hA8, 8, 1, 0);
    pushN(2, 1, 1, 16'h0000, 8'hA8, 8, 0, 0);
    pushN(1, 1, 1, 16'h0020, 8'hA8, 8, 0, 1);
    for (int r = 0; r < 2; r++) begin
      pushN(3, 1, 1, 16'h0020, 8'hA5, 5, 1, 0);
      pushN(1, 1, 1, 16'h0020, 8'hA5, 5, 1, 1);
    end
    pushN(1, 1, 1, 16'h8101, 8'hA5, 5, 0, 0);
    pushN(2, 1, 1, 16'h8101, 8'hA8, 8, 1, 0);
    pushN(3, 1, 0, 16'h8101, 8'hA8, 8, 0, 0);
    pushN(2, 1, 1, 16'h8101, 8'hA8, 8, 1, 0);
    pushN(1, 1, 1, 16'h8101, 8'hAF, 15, 1, 0);
    b_end = vecs.size();
    // Phase C: after async reset, DIRECT then fresh scan
    push(0, 3, 1, 16'h8101, 8'hA3, 3, 1, 0);
    push(1, 3, 1, 16'h8101, 8'hA3, 3, 0, 0);
    pushN(2, 1, 1, 16'h8101, 8'hA0, 0, 1, 0);
    c_end = vecs.size();

    rst_n = 1'b0;
    mode = 1'b0; select = '0; enable = 1'b1; chan_mask = '0;
    for (int k = 0; k < N; k++) inp[k*W +: W] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("reset_hold", 8'h00, 4'd0, 1'b0, 1'b0);
    end
    setDefaultInp();
    rst_n = 1'b1;

    applyStimulus(0, a_end);

    inp[9*W +: W] = 8'h5A;
    @(posedge clk); #1;
    checkOutput("inp9_change", 8'h5A, 4'd9, 1'b1, 1'b0);
    setDefaultInp();

    applyStimulus(a_end, b_end);

    #3 rst_n = 1'b0;
    #1 checkOutput("async_reset", 8'h00, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("reset_held_scan", 8'h00, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    applyStimulus(b_end, c_end);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
